// File: rtl/barrel_pkg.sv
// Shared definitions for the barrel core fetch stage: thread-id sizing and
// reset/stride defaults used by fetch, decode and execute.
package barrel_pkg;

  localparam int NUM_THREADS_DEFAULT = 8;
  localparam int RESET_PC_DEFAULT    = 0;
  localparam int PC_STRIDE_DEFAULT   = 4;

  // A single-thread core still carries a 1-bit thread id.
  function automatic int thread_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BITS_THREADS_DEFAULT = thread_bits(NUM_THREADS_DEFAULT);

  typedef logic [BITS_THREADS_DEFAULT-1:0] tid_t;

endpackage

// File: rtl/barrel_fetch_arbiter.sv
// Round-robin thread picker: first active thread strictly after rr_ptr,
// wrapping around; rr_ptr itself is the last candidate considered.
module rr_thread_arbiter
  import barrel_pkg::*;
#(
  parameter int NUM_THREADS  = NUM_THREADS_DEFAULT,
  parameter int BITS_THREADS = thread_bits(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0]  active_mask,
  input  logic [BITS_THREADS-1:0] rr_ptr,
  output logic [BITS_THREADS-1:0] sel,
  output logic                    any_active
);

  logic [BITS_THREADS-1:0] cand;

  // Scan from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    sel        = '0;
    any_active = 1'b0;
    cand       = '0;
    for (int i = NUM_THREADS; i >= 1; i--) begin
      cand = BITS_THREADS'((int'(rr_ptr) + i) % NUM_THREADS);
      if (active_mask[cand]) begin
        sel        = cand;
        any_active = 1'b1;
      end
    end
  end

endmodule

// File: rtl/barrel_fetch.sv
// Barrel-core fetch stage: per-thread PCs, round-robin issue to a one-cycle
// instruction memory, registered fetch packet with stall hold and squash.
module barrel_fetch
  import barrel_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_THREADS   = NUM_THREADS_DEFAULT,
  parameter int BITS_THREADS  = thread_bits(NUM_THREADS),
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC  = ADDRESS_WIDTH'(RESET_PC_DEFAULT),
  parameter logic [ADDRESS_WIDTH-1:0] PC_STRIDE = ADDRESS_WIDTH'(PC_STRIDE_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  input  logic [BITS_THREADS-1:0]  tid_e,
  input  logic                     thr_start,
  input  logic [BITS_THREADS-1:0]  thr_start_tid,
  input  logic [ADDRESS_WIDTH-1:0] thr_start_pc,
  input  logic                     thr_halt,
  input  logic [BITS_THREADS-1:0]  thr_halt_tid,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic                     valid_f,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  output logic [DATA_WIDTH-1:0]    instr_f,
  output logic [BITS_THREADS-1:0]  tid_f,
  output logic [NUM_THREADS-1:0]   active_mask
);

  logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THREADS];
  logic [NUM_THREADS-1:0]   active_q;
  logic [BITS_THREADS-1:0]  rr_ptr_q;
  logic [BITS_THREADS-1:0]  sel;
  logic                     any_active;
  logic                     issue;
  logic                     valid_q;
  logic                     hold_valid_q;
  logic [DATA_WIDTH-1:0]    hold_q;
  logic [ADDRESS_WIDTH-1:0] pc_f_q;
  logic [BITS_THREADS-1:0]  tid_f_q;

  rr_thread_arbiter #(
    .NUM_THREADS  (NUM_THREADS),
    .BITS_THREADS (BITS_THREADS)
  ) u_arbiter (
    .active_mask (active_q),
    .rr_ptr      (rr_ptr_q),
    .sel         (sel),
    .any_active  (any_active)
  );

  assign issue     = en & any_active;
  assign imem_req  = issue;
  assign imem_addr = pc_q[sel];

  // Per-thread PC and active bit; start beats redirect beats sequential step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        pc_q[t] <= RESET_PC;
      end
      active_q <= '1;
    end else if (en) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (thr_start && thr_start_tid == BITS_THREADS'(t)) begin
          pc_q[t] <= thr_start_pc;
        end else if (pc_src_e && tid_e == BITS_THREADS'(t)) begin
          pc_q[t] <= pc_target_e;
        end else if (issue && sel == BITS_THREADS'(t)) begin
          pc_q[t] <= pc_q[t] + PC_STRIDE;
        end

        if (thr_start && thr_start_tid == BITS_THREADS'(t)) begin
          active_q[t] <= 1'b1;
        end else if (thr_halt && thr_halt_tid == BITS_THREADS'(t)) begin
          active_q[t] <= 1'b0;
        end
      end
    end
  end

  // F2 packet registers and the stall hold of the word returned by memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= BITS_THREADS'(NUM_THREADS - 1);
      valid_q      <= 1'b0;
      pc_f_q       <= '0;
      tid_f_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else if (en) begin
      hold_valid_q <= 1'b0;
      valid_q      <= issue & ~(pc_src_e && sel == tid_e);
      if (issue) begin
        rr_ptr_q <= sel;
        pc_f_q   <= pc_q[sel];
        tid_f_q  <= sel;
      end
    end else if (!hold_valid_q && valid_q) begin
      hold_q       <= imem_rdata;
      hold_valid_q <= 1'b1;
    end
  end

  assign valid_f     = valid_q & ~(pc_src_e && tid_f_q == tid_e);
  assign pc_f        = pc_f_q;
  assign pc_plus4_f  = pc_f_q + PC_STRIDE;
  assign instr_f     = hold_valid_q ? hold_q : imem_rdata;
  assign tid_f       = tid_f_q;
  assign active_mask = active_q;

endmodule

// File: doc/barrel_fetch.md
# barrel_fetch

Parametrised fetch stage for the barrel (fine-grained multithreaded) core. It holds one PC per hardware thread and selects the next active thread round-robin, skipping threads that are halted. It drives a synchronous instruction memory with one-cycle read latency and presents a registered, valid-qualified fetch packet to decode. It also handles per-thread redirects, thread start/halt, pipeline stall with instruction hold, and wrong-path squash when fewer threads than pipeline stages are configured.

## Interface
- DATA_WIDTH, 32, instruction width
- ADDRESS_WIDTH, 32, PC width
- NUM_THREADS, 8, hardware threads (>=1)
- BITS_THREADS, max(1,$clog2(NUM_THREADS)), thread-id width
- RESET_PC, 0, PC of every thread after reset
- PC_STRIDE, 4, sequential increment
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  advance; 0 freezes all state and ignores redirect/start/halt inputs
- pc_src_e  in  1  redirect request from execute
- pc_target_e  in  ADDRESS_WIDTH  redirect target
- tid_e  in  BITS_THREADS  redirected thread
- thr_start  in  1  activate thread
- thr_start_tid  in  BITS_THREADS  thread to start
- thr_start_pc  in  ADDRESS_WIDTH  start PC
- thr_halt  in  1  deactivate thread
- thr_halt_tid  in  BITS_THREADS  thread to halt
- imem_req  out  1  read strobe
- imem_addr  out  ADDRESS_WIDTH  read address
- imem_rdata  in  DATA_WIDTH  read data, valid exactly one cycle after imem_req
- valid_f  out  1  fetch packet valid
- pc_f, pc_plus4_f  out  ADDRESS_WIDTH  packet PC, PC+PC_STRIDE
- instr_f  out  DATA_WIDTH  packet instruction
- tid_f  out  BITS_THREADS  packet thread
- active_mask  out  NUM_THREADS  per-thread active bits

## Operation
- F1 (select): the arbiter picks the first active thread strictly after rr_ptr, wrapping; imem_req = en & any active; imem_addr = pc[sel]; rr_ptr <= sel on issue.
- F2 (packet): pc_f, tid_f and valid_q are registered from F1. instr_f = hold_valid ? hold : imem_rdata.
- valid_f = valid_q & ~(pc_src_e & tid_f==tid_e). The gating is combinational and squashes a wrong-path instruction before decode.
- Issue with en=1: pc[sel] <= pc[sel]+PC_STRIDE, unless overridden. valid_q <= issued & ~(pc_src_e & sel==tid_e).
- PC write priority per thread: thr_start > pc_src_e > sequential increment.
- A redirect to an inactive thread updates its PC but does not activate it.
- Active-bit priority: thr_start sets, thr_halt clears; start wins when both name the same tid. A halt does not recall an instruction issued in the same cycle.
- No active thread: imem_req=0, valid_q <= 0, rr_ptr held.
- Stall: at an edge with en=0, hold_valid=0 and valid_q=1, capture hold <= imem_rdata and set hold_valid. Any edge with en=1 clears hold_valid.
- All PC arithmetic is modulo 2^ADDRESS_WIDTH.

## Timing
- Reset values: all pc = RESET_PC; active_mask = all ones; rr_ptr = NUM_THREADS-1 (first grant is thread 0); valid_q = 0, so valid_f = 0; pc_f = 0; tid_f = 0; hold_valid = 0; imem_req follows en.
- Latency: issue in cycle T; packet valid in T+1 with instr_f = imem_rdata.
- Redirect/start in cycle T: the next issue of that thread fetches the new PC, in T+1 at the earliest.
- Reset mid-stall drops hold and packet; no imem_req is required to be cancelled.
- valid_f has a combinational path from pc_src_e/tid_e; downstream must tolerate it.

## Structure
- Package barrel_pkg: BITS_THREADS derivation, RESET_PC/PC_STRIDE defaults, thread-id typedef shared with decode/execute.
- Sub-module rr_thread_arbiter: round-robin find-next over active_mask from rr_ptr; outputs sel and any_active.
- The PC register file, hold register and priority logic stay in barrel_fetch.

## Test plan
- NUM_THREADS=4, release reset with en=1 -> tid_f 0,1,2,3,0; pc_f 0,0,0,0,4; valid_f first high one cycle after first imem_req.
- Halt tids 1 and 2 -> tid_f sequence 0,3,0,3; active_mask=4'b1001.
- NUM_THREADS=2, pc_src_e tid_e=1 target 0x100 while F2 holds tid 1 and F1 selects tid 1 -> valid_f low that cycle and next; the next tid-1 packet has pc_f=0x100.
- en low 3 cycles after issue, imem_rdata changed to 0xDEADBEEF after first stall cycle -> instr_f stays at the original word; on resume, issue continues with the next thread.
- Halt all threads -> imem_req=0, valid_f=0; thr_start tid 1 pc 0x200 -> imem_addr=0x200 next cycle, packet tid_f=1 pc_f=0x200.
- NUM_THREADS=1, redirect to 0xFFFFFFFC -> pc_plus4_f=0, next pc_f=0; simultaneous start/halt on the same tid -> thread stays active.
